// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and the future transmit path).
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  localparam int unsigned MaxDataBits = 9;

  typedef struct packed {
    logic                   ferr;
    logic                   perr;
    logic [MaxDataBits-1:0] data;
  } uart_frame_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (optional parity, 1-2 stop bits) feeding a FWFT frame FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  input  logic                          clear_i,
  output logic [DATA_BITS-1:0]          m_data_o,
  output logic                          m_perr_o,
  output logic                          m_ferr_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int unsigned Cpb  = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned CntW = (Cpb > 2) ? $clog2(Cpb) : 1;

  localparam logic [CntW-1:0] CpbLast   = CntW'(Cpb - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(Half - 1);
  localparam logic [3:0]      DataLast  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast  = 4'(STOP_BITS - 1);
  localparam logic            ParityEn  = (PARITY_EN != 0);
  localparam logic            ParityOdd = (PARITY_ODD != 0);

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  logic                 start_det;

  uart_state_e          state_q;
  logic                 busy_q;
  logic [CntW-1:0]      cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 stop_ferr;
  logic                 push_q;
  uart_frame_t          frame_q;

  uart_frame_t          head;
  logic                 empty, full, pop, drop;
  logic                 overflow_q;
  logic                 unused_head;

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s      = sync_q[1];
  assign start_det = rx_en_i & rx_prev_q & ~rx_s;
  assign stop_ferr = ferr_q | ~rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      push_q <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (cnt_q == CpbLast) begin
            cnt_q  <= '0;
            data_q <= {rx_s, data_q[DATA_BITS-1:1]};
            if (bit_q == DataLast) begin
              bit_q   <= '0;
              state_q <= ParityEn ? StParity : StStop;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (cnt_q == CpbLast) begin
            cnt_q   <= '0;
            perr_q  <= (^data_q) ^ rx_s ^ ParityOdd;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (cnt_q == CpbLast) begin
            cnt_q <= '0;
            if (bit_q == StopLast) begin
              push_q       <= 1'b1;
              frame_q.ferr <= stop_ferr;
              frame_q.perr <= perr_q;
              frame_q.data <= MaxDataBits'(data_q);
              // A break holds the line low; wait for it to release before hunting again.
              if (stop_ferr && data_q == '0) begin
                state_q <= StBreak;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q  <= bit_q + 1'b1;
              ferr_q <= stop_ferr;
            end
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pop  = m_valid_o & m_ready_i;
  assign drop = push_q & full & ~pop;

  sync_fifo #(
    .Width($bits(uart_frame_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(clear_i),
    .push_i (push_q),
    .wdata_i(frame_q),
    .pop_i  (pop),
    .rdata_o(head),
    .empty_o(empty),
    .full_o (full),
    .count_o(level_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop | (overflow_q & ~clear_i);
    end
  end

  assign m_valid_o   = ~empty;
  assign m_data_o    = head.data[DATA_BITS-1:0];
  assign m_perr_o    = head.perr;
  assign m_ferr_o    = head.ferr;
  assign overflow_o  = overflow_q;
  assign busy_o      = busy_q;
  assign unused_head = ^head.data;

endmodule
